// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces whole frames and
// encodes the lowest-index pressed key plus a game direction code.
// Latency: outputs update one cycle after the COMMIT that accepts a frame.
// Backpressure: none; a free-running scanner whose outputs are plain levels and strobes.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   keypad_col[3:0]    - column sense, active low, bit (3-j) = column j
//   keypad_row[3:0]    - row drive, row i pulls bit (3-i) low
//   dir[1:0]           - last accepted direction (0 up, 1 right, 2 left, 3 down)
//   key_code[3:0]      - accepted key index row*4+col, lowest index wins
//   key_valid          - accepted frame has at least one key down
//   key_pulse          - one-cycle strobe on a newly accepted key
// Optional: define KEYPAD_AUTOREPEAT_EN to re-fire key_pulse every REPEAT_FRAMES
// frames while the same non-empty frame stays accepted.
module keypad_scanner #(
  parameter int SCAN_DIV      = 5000,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int REPEAT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic [1:0] dir,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic {
    S_SCAN   = 1'b0,
    S_COMMIT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       row_q;
  logic [15:0]      snap_q;
  logic [15:0]      prev_q;
  logic [STB_W-1:0] stable_q;
  logic [3:0]       keypad_row_q;
  logic [1:0]       dir_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_pulse_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q;
`endif

  // Lowest set bit index of a frame; 0 when the frame is empty.
  function automatic logic [3:0] lowest_set(input logic [15:0] f);
    lowest_set = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (f[k]) lowest_set = 4'(k);
    end
  endfunction

  logic [3:0]       col_bits_d;
  logic [1:0]       row_d;
  logic             match_d;
  logic [STB_W-1:0] stable_d;
  logic             accept_d;
  logic [3:0]       code_d;
  logic [1:0]       dir_d;

  always_comb begin
    // Reverse and invert so that bit j of the snapshot nibble is column j.
    col_bits_d = ~{keypad_col[0], keypad_col[1], keypad_col[2], keypad_col[3]};
    row_d      = row_q + 2'd1;
    match_d    = (snap_q == prev_q);
    if (!match_d) begin
      stable_d = '0;
    end else if (stable_q == STB_W'(DEBOUNCE_CNT)) begin
      stable_d = stable_q;
    end else begin
      stable_d = stable_q + STB_W'(1);
    end
    // Accept only on the transition into DEBOUNCE_CNT, never while saturated.
    accept_d = match_d && (stable_q == STB_W'(DEBOUNCE_CNT - 1));
    code_d   = lowest_set(snap_q);
    dir_d    = dir_q;
    case (code_d)
      4'd1:    dir_d = 2'd0;
      4'd4:    dir_d = 2'd2;
      4'd6:    dir_d = 2'd1;
      4'd9:    dir_d = 2'd3;
      default: dir_d = dir_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SCAN;
      cnt_q        <= '0;
      row_q        <= 2'd0;
      snap_q       <= '0;
      prev_q       <= '0;
      stable_q     <= '0;
      keypad_row_q <= 4'b0111;
      dir_q        <= 2'd1;
      key_code_q   <= 4'd0;
      key_valid_q  <= 1'b0;
      key_pulse_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      key_pulse_q <= 1'b0;
      case (state_q)
        S_SCAN: begin
          if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            snap_q[{row_q, 2'b00} +: 4] <= col_bits_d;
            cnt_q        <= '0;
            row_q        <= row_d;
            keypad_row_q <= ~(4'b1000 >> row_d);
            if (row_q == 2'd3) state_q <= S_COMMIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_COMMIT: begin
          stable_q <= stable_d;
          prev_q   <= snap_q;
          snap_q   <= '0;
          state_q  <= S_SCAN;
          if (accept_d) begin
            key_valid_q <= |snap_q;
            if (|snap_q) begin
              key_code_q <= code_d;
              dir_q      <= dir_d;
              if (!key_valid_q || (code_d != key_code_q)) key_pulse_q <= 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q <= '0;
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (key_valid_q) begin
            // Held key: re-strobe every REPEAT_FRAMES commits.
            if (rep_q == REP_W'(REPEAT_FRAMES - 1)) begin
              key_pulse_q <= 1'b1;
              rep_q       <= '0;
            end else begin
              rep_q <= rep_q + REP_W'(1);
            end
          end
`endif
        end
        default: state_q <= S_SCAN;
      endcase
    end
  end

  assign keypad_row = keypad_row_q;
  assign dir        = dir_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_pulse  = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural key matrix.
// SCAN_DIV=4, DEBOUNCE_CNT=2, REPEAT_FRAMES=3; one frame is 17 cycles.
// Pulses are counted on the falling edge and compared per window of frames.
module tb_keypad_scanner;

  localparam int FRAME = 17;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  keypad_col;
  logic [3:0]  keypad_row;
  logic [1:0]  dir;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pulse;

  logic [15:0] keys;
  int          n_cmp;
  int          n_bad;
  int          pulses;
  int          p0;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (2),
    .REPEAT_FRAMES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keypad_col(keypad_col),
    .keypad_row(keypad_row),
    .dir       (dir),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key (i,j) pulls column bit (3-j) low while row i is driven.
  always_comb begin
    keypad_col = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (!keypad_row[3-i]) begin
        for (int j = 0; j < 4; j++) begin
          if (keys[i*4+j]) keypad_col[3-j] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (key_pulse) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n frames; lands one step after the falling edge following a COMMIT.
  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] er;
    n_cmp  = 0;
    n_bad  = 0;
    pulses = 0;
    keys   = 16'h0000;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_row",   32'(keypad_row), 32'h7);
    check("rst_dir",   32'(dir),        32'd1);
    check("rst_code",  32'(key_code),   32'd0);
    check("rst_valid", 32'(key_valid),  32'd0);
    check("rst_pulse", 32'(key_pulse),  32'd0);
    rst = 1'b0;
    #1;

    // Row drive sequence for frame 0, ending with the COMMIT cycle on row0.
    for (int c = 0; c < FRAME; c++) begin
      er = (c == 16) ? 4'b0111 : ~(4'b1000 >> (c / 4));
      check($sformatf("row_c%0d", c), 32'(keypad_row), 32'(er));
      @(negedge clk);
      #1;
    end

    // Key 6 held: accepted on the 3rd COMMIT.
    keys = 16'h0040;
    p0 = pulses;
    frames(2);
    check("k6_early_valid", 32'(key_valid), 32'd0);
    check("k6_early_code",  32'(key_code),  32'd0);
    frames(1);
    check("k6_pulse_now", 32'(key_pulse), 32'd1);
    check("k6_code",      32'(key_code),  32'd6);
    check("k6_valid",     32'(key_valid), 32'd1);
    check("k6_dir",       32'(dir),       32'd1);
    check("k6_npulse",    32'(pulses - p0), 32'd1);

    // Key 9 bouncing every other frame: nothing accepted.
    p0 = pulses;
    for (int f = 0; f < 4; f++) begin
      keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      frames(1);
    end
    check("bnc_code",   32'(key_code),  32'd6);
    check("bnc_dir",    32'(dir),       32'd1);
    check("bnc_valid",  32'(key_valid), 32'd1);
    check("bnc_npulse", 32'(pulses - p0), 32'(AR));

    // Then clean for 3 frames.
    keys = 16'h0200;
    p0 = pulses;
    frames(3);
    check("k9_code",   32'(key_code),  32'd9);
    check("k9_dir",    32'(dir),       32'd3);
    check("k9_pulse",  32'(key_pulse), 32'd1);
    check("k9_npulse", 32'(pulses - p0), 32'(1 + AR));

    // Keys 1 and 3 together: lowest index wins.
    keys = 16'h000A;
    p0 = pulses;
    frames(2);
    check("k13_early_code", 32'(key_code), 32'd9);
    frames(1);
    check("k13_code",   32'(key_code), 32'd1);
    check("k13_dir",    32'(dir),      32'd0);
    check("k13_npulse", 32'(pulses - p0), 32'd1);

    // Release: key_valid falls, no pulse, dir and code held.
    keys = 16'h0000;
    p0 = pulses;
    frames(3);
    check("rel_valid",  32'(key_valid), 32'd0);
    check("rel_dir",    32'(dir),       32'd0);
    check("rel_code",   32'(key_code),  32'd1);
    check("rel_npulse", 32'(pulses - p0), 32'd0);

    // Key 4 pressed and held.
    keys = 16'h0010;
    p0 = pulses;
    frames(3);
    check("k4_code",   32'(key_code), 32'd4);
    check("k4_dir",    32'(dir),      32'd2);
    check("k4_npulse", 32'(pulses - p0), 32'd1);
    p0 = pulses;
    frames(6);
    check("hold_npulse", 32'(pulses - p0), 32'(2 * AR));
    check("hold_dir",    32'(dir),       32'd2);
    check("hold_valid",  32'(key_valid), 32'd1);

    // Reset in the middle of row 2, key 4 still held.
    repeat (10) @(negedge clk);
    #1;
    check("pre_rst_row", 32'(keypad_row), 32'hD);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_row",   32'(keypad_row), 32'h7);
    check("mid_rst_dir",   32'(dir),        32'd1);
    check("mid_rst_code",  32'(key_code),   32'd0);
    check("mid_rst_valid", 32'(key_valid),  32'd0);
    check("mid_rst_pulse", 32'(key_pulse),  32'd0);
    rst = 1'b0;
    p0 = pulses;
    frames(2);
    check("post_rst_early_valid", 32'(key_valid), 32'd0);
    frames(1);
    check("post_rst_valid",  32'(key_valid), 32'd1);
    check("post_rst_code",   32'(key_code),  32'd4);
    check("post_rst_dir",    32'(dir),       32'd2);
    check("post_rst_npulse", 32'(pulses - p0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
